// File: rtl/gpu_pkg.sv
// Shared GPU pipeline types: frame dispatcher state encoding and per-triangle
// address strides derived from the vertex/colour format parameters.
package gpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } dispatch_state_t;

  function automatic int unsigned TRI_VERTEX_BYTES(input int unsigned vertex_size);
    return 3 * vertex_size;
  endfunction

  function automatic int unsigned TRI_COLOR_BYTES(input int unsigned color_width);
    return color_width / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority first-free selector: grants the first requesting lane at or
// after the pointer, wrapping around, as a one-hot vector.
module rr_arbiter #(
  parameter int unsigned LANES = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [LANES-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [LANES-1:0] grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      idx = PTR_W'((32'(ptr) + i) % LANES);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Frame-level triangle scheduler: walks a frame's triangles and dispatches them
// round-robin over LANES start/eoc lanes, then drains and raises frame_end/irq.
module frame_dispatcher
  import gpu_pkg::*;
#(
  parameter int unsigned MADDR_WIDTH = 32,
  parameter int unsigned COLOR_WIDTH = 16,
  parameter int unsigned VERTEX_SIZE = 6,
  parameter int unsigned LANES       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         abort,
  input  logic [31:0]                  triangles_count,
  input  logic [MADDR_WIDTH-1:0]       base_addr_vertex,
  input  logic [MADDR_WIDTH-1:0]       base_addr_color,
  output logic [LANES-1:0]             lane_start,
  output logic [LANES*MADDR_WIDTH-1:0] lane_addr_vertex,
  output logic [LANES*MADDR_WIDTH-1:0] lane_addr_color,
  input  logic [LANES-1:0]             lane_eoc,
  output logic                         busy,
  output logic                         frame_end,
  output logic                         aborted,
  output logic [31:0]                  tri_done,
  output logic                         proto_err,
  output logic                         irq,
  input  logic                         irq_ack
);

  localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [MADDR_WIDTH-1:0] VTX_STEP = MADDR_WIDTH'(TRI_VERTEX_BYTES(VERTEX_SIZE));
  localparam logic [MADDR_WIDTH-1:0] COL_STEP = MADDR_WIDTH'(TRI_COLOR_BYTES(COLOR_WIDTH));

  dispatch_state_t        state, state_next;
  logic [LANES-1:0]       lane_busy, grant, eoc_valid;
  logic                   grant_valid, dispatch, accept, last_dispatch;
  logic [PTR_W-1:0]       rr_ptr, ptr_after;
  logic [31:0]            count_q, disp_idx, eoc_count;
  logic [32:0]            tri_sum;
  logic [MADDR_WIDTH-1:0] acc_vertex, acc_color;

  rr_arbiter #(
    .LANES(LANES),
    .PTR_W(PTR_W)
  ) u_arb (
    .req  (~lane_busy),
    .ptr  (rr_ptr),
    .grant(grant),
    .valid(grant_valid)
  );

  // Dispatch depends only on registered state, so lane_start has no input path;
  // a lane freed by eoc only shows up in lane_busy from the next cycle.
  always_comb begin
    accept        = (state == S_IDLE) && frame_start;
    dispatch      = (state == S_DISPATCH) && grant_valid;
    lane_start    = dispatch ? grant : '0;
    last_dispatch = (disp_idx == count_q - 32'd1);
    busy          = (state != S_IDLE);
    frame_end     = (state == S_DONE);
    eoc_valid     = lane_eoc & lane_busy;
    ptr_after     = rr_ptr;
    eoc_count     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (grant[i]) ptr_after = (i == LANES - 1) ? '0 : PTR_W'(i + 1);
      eoc_count = eoc_count + 32'(eoc_valid[i]);
    end
    tri_sum = {1'b0, tri_done} + {1'b0, eoc_count};
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (frame_start) state_next = (triangles_count == '0) ? S_DONE : S_DISPATCH;
      S_DISPATCH: if (abort || (dispatch && last_dispatch)) state_next = S_DRAIN;
      S_DRAIN:    if ((lane_busy & ~lane_eoc) == '0) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      lane_busy        <= '0;
      rr_ptr           <= '0;
      count_q          <= '0;
      disp_idx         <= '0;
      acc_vertex       <= '0;
      acc_color        <= '0;
      lane_addr_vertex <= '0;
      lane_addr_color  <= '0;
      tri_done         <= '0;
      aborted          <= 1'b0;
      proto_err        <= 1'b0;
      irq              <= 1'b0;
    end else begin
      state     <= state_next;
      lane_busy <= (lane_busy & ~lane_eoc) | lane_start;
      if (|(lane_eoc & ~lane_busy)) proto_err <= 1'b1;
      // irq is set both entering and during DONE so an ack in DONE loses to set.
      if (state_next == S_DONE || state == S_DONE) irq <= 1'b1;
      else if (irq_ack)                            irq <= 1'b0;
      if (dispatch) rr_ptr <= ptr_after;
      if (accept) begin
        count_q    <= triangles_count;
        acc_vertex <= base_addr_vertex;
        acc_color  <= base_addr_color;
        disp_idx   <= '0;
        tri_done   <= '0;
        aborted    <= 1'b0;
      end else begin
        if (dispatch) begin
          acc_vertex <= acc_vertex + VTX_STEP;
          acc_color  <= acc_color + COL_STEP;
          disp_idx   <= disp_idx + 32'd1;
        end
        if (state == S_DISPATCH && abort) aborted <= 1'b1;
        tri_done <= tri_sum[32] ? '1 : tri_sum[31:0];
      end
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_start[i]) begin
          lane_addr_vertex[i*MADDR_WIDTH +: MADDR_WIDTH] <= acc_vertex;
          lane_addr_color[i*MADDR_WIDTH +: MADDR_WIDTH]  <= acc_color;
        end
      end
    end
  end

endmodule

// File: doc/frame_dispatcher.md
# frame_dispatcher

Frame-level triangle scheduler for the GPU pipeline, the parametrised successor to the single-lane start/eoc sequencing in the top level. On `frame_start` it walks `triangles_count` triangles, computes each triangle's vertex and colour addresses, and dispatches them round-robin across `LANES` independent fetch/compute lanes using a start/eoc handshake. It tracks outstanding work, supports abort, counts completed triangles, and raises `frame_end` and a sticky `irq` when the frame drains.

## Interface
- `MADDR_WIDTH`, 32: memory address width.
- `COLOR_WIDTH`, 16: colour bits per triangle; colour stride = COLOR_WIDTH/8 bytes. Must be a multiple of 8.
- `VERTEX_SIZE`, 6: bytes per vertex; vertex stride = 3*VERTEX_SIZE bytes.
- `LANES`, 4: parallel lanes, 1..16.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `frame_start`  in  1  one-cycle request to start a frame.
- `abort`  in  1  one-cycle request to stop dispatching.
- `triangles_count`  in  32  triangles in the frame; sampled on accepted `frame_start`.
- `base_addr_vertex`, `base_addr_color`  in  MADDR_WIDTH each  base addresses; sampled on accepted `frame_start`.
- `lane_start`  out  LANES  per-lane one-cycle dispatch pulse.
- `lane_addr_vertex`, `lane_addr_color`  out  LANES*MADDR_WIDTH each  per-lane addresses, packed with lane i at [i*MADDR_WIDTH +: MADDR_WIDTH].
- `lane_eoc`  in  LANES  per-lane one-cycle completion pulse.
- `busy`  out  1  high outside IDLE.
- `frame_end`  out  1  one-cycle pulse when the frame completes or the abort finishes draining.
- `aborted`  out  1  status of the last frame; cleared on the next accepted `frame_start`.
- `tri_done`  out  32  triangles completed in the current or last frame.
- `proto_err`  out  1  sticky; set when `lane_eoc` arrives on an idle lane. Cleared only by `rst`.
- `irq`  out  1  sticky interrupt.
- `irq_ack`  in  1  clears `irq`.

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: `frame_start` is accepted. It latches the count and bases, clears `tri_done` and `aborted`, resets the dispatch index, and moves to DISPATCH. If the count is 0, it moves directly to DONE.
- DISPATCH: at most one triangle per cycle is sent to the first free lane, searching from the round-robin pointer.
  - Pulse `lane_start[i]` and register that lane's addresses. Mark the lane busy. Set the pointer to i+1 mod LANES.
  - Addresses come from running accumulators, with no multiplier. Each dispatch adds 3*VERTEX_SIZE to the vertex accumulator and COLOR_WIDTH/8 to the colour accumulator. Arithmetic wraps modulo 2^MADDR_WIDTH.
  - After the last triangle is dispatched, move to DRAIN.
- DRAIN: wait until all lanes are idle, then move to DONE.
- DONE: pulse `frame_end`, set `irq`, return to IDLE. This state lasts one cycle.
- `lane_eoc[i]` on a busy lane frees that lane and increments `tri_done`, saturating at 2^32-1. Multiple eoc pulses in one cycle add their popcount.
- A lane freed by eoc is dispatchable only from the next cycle; same-cycle reuse is not allowed.
- `abort` in DISPATCH stops further dispatch, sets `aborted`, and moves to DRAIN. `abort` in IDLE, DRAIN, or DONE is ignored.
- `frame_start` while `busy` is ignored and does not change any latched value.
- `irq_ack` clears `irq`. If set and `irq_ack` occur in the same cycle, set wins.
- `lane_addr_*` hold their value until that lane's next dispatch.

## Timing
- `frame_start` accepted at cycle 0 gives the first `lane_start` at cycle 1. Dispatch is registered; there is no combinational path from inputs to `lane_start`.
- With all lanes free, N ≤ LANES triangles issue on cycles 1..N.
- The last eoc at cycle t gives DONE at t+1, with `frame_end` and the `irq` rise at t+1.
- Count = 0 gives `frame_end` at cycle 1.
- Reset: every output is 0, the state is IDLE, all lanes are free, the pointer is 0, and the accumulators are 0.
- `rst` mid-frame discards all state immediately. Any later `lane_eoc` on a lane that is now idle sets `proto_err`.

## Structure
- Shared package `gpu_pkg`: state enum `dispatch_state_t`, and the `TRI_VERTEX_BYTES` / `TRI_COLOR_BYTES` stride functions of the parameters.
- Sub-module `rr_arbiter` (LANES-wide, rotating-priority first-free select). It returns a one-hot grant and a valid flag.
- Everything else (the FSM, accumulators, lane busy vector, counters) stays in `frame_dispatcher`.

## Test plan
- Basic dispatch, LANES=4, count=3, bases 0x1000/0x8000, lanes echo eoc 5 cycles after start -> lanes 0,1,2 start on cycles 1,2,3.
  - Vertex addresses 0x1000, 0x1012, 0x1024; colour addresses 0x8000, 0x8002, 0x8004.
  - `frame_end` arrives once, `tri_done`=3, `irq`=1.
- Count=0 -> `frame_end` at cycle 1, no `lane_start`, `tri_done`=0.
- Back-pressure, count=10 with all lanes held busy 20 cycles -> only 4 starts are outstanding.
  - The 5th start goes to lane 0 no earlier than the cycle after lane 0's eoc.
  - `tri_done`=10 at the end.
- Abort after 2 dispatches with count=8 -> no further starts, `aborted`=1.
  - `frame_end` comes after the 2 eoc pulses; `tri_done`=2.
- Base address 0xFFFFFFF0, VERTEX_SIZE=6, count=2 -> the second vertex address is 0x00000002 (wraps modulo 2^32).
- `irq_ack` in the same cycle as DONE -> `irq` stays 1; an ack one cycle later clears it.
- `lane_eoc[2]` with lane 2 idle -> `proto_err`=1 and `tri_done` unchanged.
